// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the pwm_sched PWM controller.
package pwm_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

  typedef enum logic [1:0] {
    CFG_PRESC  = 2'd0,
    CFG_PERIOD = 2'd1,
    CFG_DUTY   = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_kind_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam logic [CNT_W_DEF-1:0] PERIOD_RST = '1;
  localparam logic [CNT_W_DEF-1:0] DUTY_RST   = '0;

endpackage

// File: rtl/pwm_sched_if.sv
// Control/config bus between the controller logic (master) and pwm_sched (slave).
interface pwm_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  import pwm_pkg::*;

  logic              run;
  logic              cfg_valid;
  logic              cfg_ready;
  cfg_kind_e         cfg_kind;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;
  logic              busy;

  modport master (
    output run, cfg_valid, cfg_kind, cfg_ch, cfg_data,
    input  cfg_ready, pwm_out, period_tick, busy
  );

  modport slave (
    input  run, cfg_valid, cfg_kind, cfg_ch, cfg_data,
    output cfg_ready, pwm_out, period_tick, busy
  );

endinterface

// File: rtl/pwm_presc_tick.sv
// Prescaler: emits a one-cycle tick every presc+1 cycles; held at zero by clear.
module pwm_presc_tick #(
  parameter int PRESC_W = 4
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = (presc_cnt == presc);

  always_ff @(posedge clk_in) begin
    if (!rst || clear || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_sched.sv
// Multi-channel PWM controller with shadowed configuration that takes effect
// only at period boundaries, so duty/period updates never glitch the outputs.
module pwm_sched
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic        clk_in,
  input logic        rst,
  pwm_sched_if.slave bus
);

  state_e             state;
  state_e             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_sh;
  logic [CNT_W-1:0]   period_act;
  logic [PRESC_W-1:0] presc_sh;
  logic [PRESC_W-1:0] presc_act;
  logic [CNT_W-1:0]   duty_sh  [NUM_CH];
  logic [CNT_W-1:0]   duty_act [NUM_CH];
  logic               tick;
  logic               wrap;
  logic               presc_clr;
  logic               accept;
  logic               ch_ok;
  logic [NUM_CH-1:0]  pwm_nx;

  assign presc_clr = (state == IDLE);

  pwm_presc_tick #(.PRESC_W(PRESC_W)) u_presc (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (presc_clr),
    .presc  (presc_act),
    .tick   (tick)
  );

  assign wrap          = (state != IDLE) && tick && (cnt == period_act);
  assign bus.busy      = (state != IDLE);
  assign bus.cfg_ready = rst && !(bus.busy && wrap);
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign ch_ok         = ({1'b0, bus.cfg_ch} < (CH_W+1)'(NUM_CH));

  // A request to run always wins; STOPPING only falls back to IDLE on a wrap.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (bus.run) state_nx = RUN;
      RUN:      if (!bus.run) state_nx = STOPPING;
      STOPPING: begin
        if (bus.run)   state_nx = RUN;
        else if (wrap) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_nx[i] = (state_nx != IDLE) && (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.pwm_out     <= '0;
      bus.period_tick <= 1'b0;
      presc_sh        <= '0;
      presc_act       <= '0;
      period_sh       <= PERIOD_RST;
      period_act      <= PERIOD_RST;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= DUTY_RST;
        duty_act[i] <= DUTY_RST;
      end
    end else begin
      state           <= state_nx;
      bus.pwm_out     <= pwm_nx;
      bus.period_tick <= wrap;

      if (state == IDLE) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end

      // Ready is low on wrap, so this copy never sees a same-cycle write.
      if (state == IDLE || wrap) begin
        presc_act  <= presc_sh;
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_act[i] <= duty_sh[i];
        end
      end

      if (accept) begin
        unique case (bus.cfg_kind)
          CFG_PRESC:  presc_sh  <= bus.cfg_data[PRESC_W-1:0];
          CFG_PERIOD: period_sh <= bus.cfg_data;
          CFG_DUTY:   if (ch_ok) duty_sh[bus.cfg_ch] <= bus.cfg_data;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_sched.md
Name: pwm_sched

Overview:
- Multi-channel PWM controller. Replaces the free-running divided clock with a single-domain prescaler tick that sequences a shared period counter.
- Drives NUM_CH PWM outputs from per-channel duty values.
- Configuration arrives over a valid/ready write port into shadow registers. Shadow values become active only at period boundaries, so updates never produce glitches.
- Sits between the control logic and the motor/LED drive pins.

Parameters:
- NUM_CH, 4, number of PWM channels
- CNT_W, 8, width of period/duty counter and values
- PRESC_W, 4, width of prescaler value
- CH_W, $clog2(NUM_CH), channel select width (derived)

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-low reset
- run  in  1  level request: 1 = generate PWM, 0 = stop at end of current period
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accept
- cfg_kind  in  2  0=prescaler, 1=period, 2=duty, 3=reserved (accepted, ignored)
- cfg_ch  in  CH_W  channel index for duty writes
- cfg_data  in  CNT_W  write data; prescaler uses low PRESC_W bits
- pwm_out  out  NUM_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse on the period wrap cycle
- busy  out  1  high in RUN or STOPPING

Behaviour:
- Reset (rst==0 at posedge clk_in):
  - state = IDLE; counters = 0; pwm_out = 0; period_tick = 0; busy = 0.
  - shadow and active registers: presc = 0, period = all-ones, duty[i] = 0.
  - cfg_ready = 0 while rst is low.
- Prescaler:
  - tick asserts when presc_cnt == presc_act; presc_cnt then clears, otherwise it increments.
  - presc = 0 gives a tick every cycle; presc = P gives a tick every P+1 cycles.
  - Prescaler is held at 0 in IDLE.
- Period counter:
  - Advances only on tick while not IDLE.
  - If cnt == period_act, then wrap = 1 and cnt <= 0; otherwise cnt <= cnt+1.
  - Period length = (period_act+1)*(presc_act+1) clk_in cycles.
- Output:
  - pwm_out[i] <= busy_next && (cnt < duty_act[i]), registered, so it lags cnt by one cycle.
  - duty = 0 gives constant low.
  - duty > period gives constant high.
- period_tick: registered copy of wrap; high exactly one cycle per period.
- Shadow load:
  - In IDLE, active registers track shadow every cycle.
  - In RUN/STOPPING, shadow is copied to active only on the wrap cycle.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready; shadow is updated on that edge.
  - cfg_ready = rst && !(busy && wrap): it drops for the single wrap cycle so the shadow-to-active copy never races a write.
  - A held write is accepted the following cycle and applies from the next period.
  - An out-of-range cfg_ch is accepted and ignored.
- FSM:
  - IDLE -> RUN when run==1. cnt and presc_cnt start at 0; the first tick arrives presc+1 cycles later.
  - RUN -> STOPPING when run==0.
  - STOPPING -> RUN when run==1, with no counter disturbance.
  - STOPPING -> IDLE on wrap; pwm_out goes to 0 the next cycle.
  - A wrap coinciding with run going 0 in RUN: go to STOPPING and complete one more full period.
- Reset mid-operation: immediate return to reset values on the next edge; the partial period is discarded.

Decomposition:
- Package pwm_pkg:
  - cfg_kind_e enum (CFG_PRESC=2'd0, CFG_PERIOD=2'd1, CFG_DUTY=2'd2, CFG_RSVD=2'd3)
  - state_e enum (IDLE, RUN, STOPPING)
  - reset constants PERIOD_RST and DUTY_RST
- Sub-module pwm_presc_tick: prescaler counter plus tick output, with clear input; parameter PRESC_W.

Test Plan:
- Basic duty:
  - Stimulus: reset, write presc=0, period=9, duty0=3, raise run.
  - Required: pwm_out[0] high 3 of every 10 cycles; period_tick every 10 cycles; busy=1.
- Prescaler:
  - Stimulus: presc=3, period=9, duty0=3.
  - Required: 40-cycle period, pwm_out[0] high for 12 cycles; a tick every 4 cycles.
- Mid-period duty update:
  - Stimulus: write duty0=7 at cnt=4.
  - Required: current period keeps 3 high; the next period is 7 high.
  - Stimulus: a write held valid across the wrap cycle.
  - Required: cfg_ready=0 for exactly that cycle; write accepted next cycle and effective one period later.
- Duty extremes:
  - duty=0 -> constant low.
  - duty=10 with period=9 -> constant high.
  - period=0, duty=1 -> constant high with period_tick every presc+1 cycles.
- Stop/restart:
  - Stimulus: drop run at cnt=2 with period=9.
  - Required: outputs continue to wrap, then busy=0 and pwm_out=0.
  - Stimulus: re-raise run during STOPPING.
  - Required: no gap and no period restart.
- Reset mid-run:
  - Stimulus: rst=0 at cnt=5.
  - Required: next edge pwm_out=0, busy=0, cfg_ready=0; after release, period reads back all-ones behaviour and duty=0.
